// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared constants and fetch state encoding for the fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam logic [15:0] NOP_INST = 16'h0800;
    localparam logic [4:0]  HALT_OPC = 5'b00000;
    localparam logic [15:0] PC_STEP  = 16'd2;

    typedef enum logic [2:0] {
        S_REQ    = 3'd0,
        S_WAIT   = 3'd1,
        S_HOLD   = 3'd2,
        S_FLUSH  = 3'd3,
        S_HALTED = 3'd4
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] inst);
        return inst[15:11] == HALT_OPC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory request/response bus between fetch and imem.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if;

    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_busy;
    logic        imem_done;
    logic [15:0] imem_data;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_busy,
        input  imem_done,
        input  imem_data
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_busy,
        output imem_done,
        output imem_data
    );

endinterface
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buf
// Brief    : 32-bit {inst, PC_inc} buffer with load enable and valid flag.
// Revision : 1.0
// ============================================================================
module fetch_hold_buf (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic        i_clear,
    input  wire logic [31:0] i_data,
    output logic      [31:0] o_data,
    output logic             o_valid
);

    logic [31:0] r_data;
    logic        r_valid;

    // Load wins over clear so a capture in the same cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Fetch stage: owns the PC, the imem handshake and the IF/ID feed.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic        takeBranch,
    input  wire logic [15:0] branch_target,
    fetch_unit_if.master     imem,
    output logic      [15:0] inst_IF,
    output logic      [15:0] PC_inc_IF,
    output logic             inst_stall
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  r_pc;
    logic [15:0]  w_pc_nxt;
    logic [15:0]  w_pc_inc;
    logic         w_accept;
    logic         w_deliver;
    logic         w_outstanding;
    logic         w_hold_load;
    logic         w_hold_clear;
    logic [31:0]  w_hold_data;
    logic         w_hold_valid;

    assign w_pc_inc       = r_pc + PC_STEP;
    assign imem.imem_rd   = (r_state == S_REQ) && !rst;
    assign imem.imem_addr = r_pc;

    assign w_accept      = imem.imem_rd && !imem.imem_busy;
    assign w_deliver     = imem.imem_done && (w_accept || (r_state == S_WAIT));
    // A request stays in flight until its response arrives, even if squashed.
    assign w_outstanding = (w_accept || (r_state == S_WAIT) || (r_state == S_FLUSH))
                           && !imem.imem_done;

    assign w_hold_load  = w_deliver && stall && !takeBranch;
    assign w_hold_clear = takeBranch || ((r_state == S_HOLD) && !stall);

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_data  ({imem.imem_data, w_pc_inc}),
        .o_data  (w_hold_data),
        .o_valid (w_hold_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        inst_IF     = NOP_INST;
        PC_inc_IF   = r_pc;
        inst_stall  = 1'b1;

        if (takeBranch) begin
            w_pc_nxt    = branch_target & 16'hFFFE;
            w_state_nxt = w_outstanding ? S_FLUSH : S_REQ;
        end else begin
            case (r_state)
                S_REQ, S_WAIT: begin
                    if (w_deliver) begin
                        inst_IF    = imem.imem_data;
                        PC_inc_IF  = w_pc_inc;
                        inst_stall = 1'b0;
                        if (stall) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = is_halt(imem.imem_data) ? S_HALTED : S_REQ;
                        end
                    end else if (w_accept) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_HOLD: begin
                    inst_IF    = w_hold_data[31:16];
                    PC_inc_IF  = w_hold_data[15:0];
                    inst_stall = !w_hold_valid;
                    if (!stall) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (imem.imem_done) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_HALTED: begin
                    w_state_nxt = S_HALTED;
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
